// File: rtl/ordered_issue_queue_if.sv
// Dispatch/commit/regfile/issue bundle of the ordered issue queue.
// The queue takes the slave side; dispatch, commit, regfile and EXU drive the master side.
interface ordered_issue_queue_if #(
    parameter int DEPTH     = 8,
    parameter int ENQ_WIDTH = 2,
    parameter int ROB_W     = 7,
    parameter int PREG_W    = 7,
    parameter int DATA_W    = 64,
    parameter int PAYLOAD_W = 48
);
    logic [ENQ_WIDTH-1:0]                enq_valid;
    logic                                enq_ready;
    logic [ENQ_WIDTH-1:0][ROB_W-1:0]     enq_rob_idx;
    logic [ENQ_WIDTH-1:0][PREG_W-1:0]    enq_rs1;
    logic [ENQ_WIDTH-1:0][PREG_W-1:0]    enq_rd;
    logic [ENQ_WIDTH-1:0][PAYLOAD_W-1:0] enq_payload;
    logic [ROB_W-1:0]                    commit_rob_idx;
    logic                                redirect;
    logic [ROB_W-1:0]                    redirect_rob_idx;
    logic                                exu_ready;
    logic                                rf_ren;
    logic [PREG_W-1:0]                   rf_raddr;
    logic [PREG_W-1:0]                   rf_rd;
    logic [DATA_W-1:0]                   rf_rdata;
    logic                                issue_valid;
    logic [ROB_W-1:0]                    issue_rob_idx;
    logic [DATA_W-1:0]                   issue_rs1_data;
    logic [PAYLOAD_W-1:0]                issue_payload;
    logic [$clog2(DEPTH):0]              count;

    modport master (
        output enq_valid, enq_rob_idx, enq_rs1, enq_rd, enq_payload,
               commit_rob_idx, redirect, redirect_rob_idx, exu_ready, rf_rdata,
        input  enq_ready, rf_ren, rf_raddr, rf_rd,
               issue_valid, issue_rob_idx, issue_rs1_data, issue_payload, count
    );

    modport slave (
        input  enq_valid, enq_rob_idx, enq_rs1, enq_rd, enq_payload,
               commit_rob_idx, redirect, redirect_rob_idx, exu_ready, rf_rdata,
        output enq_ready, rf_ren, rf_raddr, rf_rd,
               issue_valid, issue_rob_idx, issue_rs1_data, issue_payload, count
    );
endinterface

// File: rtl/ordered_issue_queue.sv
// In-order issue queue for serializing ops: head issues only at ROB commit, 2-cycle issue pipe.
// Define ORDERED_IQ_PERF_EN to add the perf_stall_cnt / perf_full_cnt counters.
module ordered_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int ENQ_WIDTH = 2,
    parameter int ROB_W     = 7,
    parameter int PREG_W    = 7,
    parameter int DATA_W    = 64,
    parameter int PAYLOAD_W = 48
) (
    input  logic clk,
    input  logic rst,
    ordered_issue_queue_if.slave iq
`ifdef ORDERED_IQ_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_full_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW:0] ptr_t;
    localparam ptr_t ENQ_LIM = ptr_t'(DEPTH - ENQ_WIDTH);

    logic [ROB_W-1:0]     rob_q [DEPTH];
    logic [PREG_W-1:0]    rs1_q [DEPTH];
    logic [PREG_W-1:0]    rd_q  [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];

    ptr_t          head, tail, cnt, keep;
    ptr_t          off [ENQ_WIDTH+1];
    logic [PW-1:0] wr_slot [ENQ_WIDTH];
    logic [PW-1:0] head_slot;
    logic          empty, head_match, enq_fire, select, kill;

    logic [2:1]           vld_pipe;
    logic [ROB_W-1:0]     s1_rob;
    logic [PAYLOAD_W-1:0] s1_pay;

    // Wrap flag in the MSB: equal flags compare directly, differing flags invert the sense.
    function automatic logic younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
        return (a[ROB_W-1] == b[ROB_W-1]) ? (a[ROB_W-2:0] > b[ROB_W-2:0])
                                          : (a[ROB_W-2:0] < b[ROB_W-2:0]);
    endfunction

    assign cnt        = tail - head;
    assign empty      = (head == tail);
    assign head_slot  = head[PW-1:0];
    assign head_match = (rob_q[head_slot] == iq.commit_rob_idx);

    assign iq.count     = cnt;
    assign iq.enq_ready = (cnt <= ENQ_LIM);
    assign enq_fire     = iq.enq_ready & (|iq.enq_valid) & ~iq.redirect;
    assign select       = ~empty & head_match & ~iq.redirect & iq.exu_ready;

    assign iq.rf_ren   = select;
    assign iq.rf_raddr = empty ? '0 : rs1_q[head_slot];
    assign iq.rf_rd    = empty ? '0 : rd_q[head_slot];

    // Lane compaction: each valid lane lands after the valid lanes below it.
    always_comb begin
        off[0] = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            off[i+1]   = off[i] + ptr_t'(iq.enq_valid[i]);
            wr_slot[i] = tail[PW-1:0] + off[i][PW-1:0];
        end
    end

    // Survivors of a flush are a prefix of the occupied entries, so counting them gives the new tail.
    always_comb begin
        keep = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (ptr_t'(j) < cnt && !younger(rob_q[head_slot + PW'(j)], iq.redirect_rob_idx))
                keep = keep + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_fire && iq.enq_valid[i]) begin
                rob_q[wr_slot[i]] <= iq.enq_rob_idx[i];
                rs1_q[wr_slot[i]] <= iq.enq_rs1[i];
                rd_q[wr_slot[i]]  <= iq.enq_rd[i];
                pay_q[wr_slot[i]] <= iq.enq_payload[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (select)
                head <= head + ptr_t'(1);
            if (iq.redirect)
                tail <= head + keep;
            else if (enq_fire)
                tail <= tail + off[ENQ_WIDTH];
        end
    end

    assign kill           = iq.redirect & younger(s1_rob, iq.redirect_rob_idx);
    assign iq.issue_valid = vld_pipe[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe          <= '0;
            s1_rob            <= '0;
            s1_pay            <= '0;
            iq.issue_rob_idx  <= '0;
            iq.issue_rs1_data <= '0;
            iq.issue_payload  <= '0;
        end else begin
            vld_pipe[1] <= select;
            vld_pipe[2] <= vld_pipe[1] & ~kill;
            if (select) begin
                s1_rob <= rob_q[head_slot];
                s1_pay <= pay_q[head_slot];
            end
            if (vld_pipe[1] && !kill) begin
                iq.issue_rob_idx  <= s1_rob;
                iq.issue_rs1_data <= iq.rf_rdata;
                iq.issue_payload  <= s1_pay;
            end
        end
    end

`ifdef ORDERED_IQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            if (!empty && head_match && !iq.exu_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (!iq.enq_ready && (|iq.enq_valid) && perf_full_cnt != '1)
                perf_full_cnt <= perf_full_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: doc/ordered_issue_queue.md
# ordered_issue_queue

In-order, non-speculative issue queue for serializing ops (CSR, fence, and other ops that must execute at the ROB head). It is the parametrised successor of the single-lane CSR queue. It accepts up to `ENQ_WIDTH` ops per cycle from dispatch, holds them in program order, and releases the head only when its ROB index equals the committing index. It reads the source register, drives a 2-cycle issue pipeline, and recovers its tail on a backend redirect.

## Interface

**Parameters** (name, default, meaning):
- `DEPTH`, 8: entry count; power of two, ≥ 2·`ENQ_WIDTH`.
- `ENQ_WIDTH`, 2: dispatch lanes per cycle, 1..4.
- `ROB_W`, 7: ROB index width; the MSB is the wrap flag.
- `PREG_W`, 7: physical register index width.
- `DATA_W`, 64: register data width.
- `PAYLOAD_W`, 48: opaque issue-bundle width.

**Ports** (name, direction, width, meaning):
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `enq_valid`, in, `ENQ_WIDTH`: per-lane enqueue request; set bits need not be contiguous.
- `enq_ready`, out, 1: high when free entries ≥ `ENQ_WIDTH`.
- `enq_rob_idx`, in, `ENQ_WIDTH`×`ROB_W`: ROB index per lane.
- `enq_rs1`, in, `ENQ_WIDTH`×`PREG_W`: source preg per lane.
- `enq_rd`, in, `ENQ_WIDTH`×`PREG_W`: destination preg per lane.
- `enq_payload`, in, `ENQ_WIDTH`×`PAYLOAD_W`: bundle per lane.
- `commit_rob_idx`, in, `ROB_W`: ROB index currently at commit head.
- `redirect`, in, 1: backend flush.
- `redirect_rob_idx`, in, `ROB_W`: flush point; strictly younger ops die.
- `exu_ready`, in, 1: execution unit can accept a select this cycle.
- `rf_ren`, out, 1: register read/wakeup request; equals select.
- `rf_raddr`, out, `PREG_W`: head rs1.
- `rf_rd`, out, `PREG_W`: head rd, for the wakeup broadcast.
- `rf_rdata`, in, `DATA_W`: read data, valid the cycle after `rf_ren`.
- `issue_valid`, out, 1: issue strobe.
- `issue_rob_idx`, out, `ROB_W`: ROB index of the issued op.
- `issue_rs1_data`, out, `DATA_W`: source operand.
- `issue_payload`, out, `PAYLOAD_W`: bundle of the issued op.
- `count`, out, `$clog2(DEPTH)+1`: number of occupied entries.

## Operation

**Storage and pointers**
- Circular buffer with `head`/`tail` pointers of `$clog2(DEPTH)` bits plus a wrap bit each.
- Empty when head equals tail including the wrap bit.
- `count = tail − head`, computed modulo 2·`DEPTH`.
- `enq_ready = (DEPTH − count) ≥ ENQ_WIDTH`. It is all-or-nothing and is never a per-lane partial accept.

**Enqueue** (`enq_ready & |enq_valid & ~redirect`)
- Lane i is written at `tail + popcount(enq_valid[i-1:0])`, so lanes are compacted in lane order.
- `tail` advances by `popcount(enq_valid)`.
- Valid lanes arriving while `enq_ready` is low are dropped. Dispatch must hold them.

**Select** (`select = ~empty & (head.rob_idx == commit_rob_idx) & ~redirect & exu_ready`)
- Drives `rf_ren`, `rf_raddr` and `rf_rd` combinationally.
- `head` advances by 1 on the next edge.

**Issue pipeline**
- Stage S1 registers the select flag, the ROB index and the payload.
- S1 captures `rf_rdata` into S2 outputs at the following edge.
- S1 is killed if `redirect` is high in S1 and the S1 op is younger than `redirect_rob_idx`.

**Age compare**
- a is younger than b iff `(a.flag == b.flag) ? a.idx > b.idx : a.idx < b.idx`.

**Redirect recovery**
- Entries are in program order, so the survivors form a prefix.
- `keep` = number of occupied entries not younger than `redirect_rob_idx`.
- Next `tail = head + keep`, wrap bit included.
- Payload RAM contents are untouched.

## Timing

- **Reset:** `head = tail = 0`, both wrap bits 0, S1/S2 valid 0.
- **Output values after reset:** `issue_valid=0`, `rf_ren=0`, `enq_ready=1`, `count=0`, data outputs 0.
- **Select-to-issue latency:** select in cycle T gives `rf_ren` in T and `issue_valid` in T+2.
- **Throughput:** at most one issue per cycle.
- **Enqueue-to-select:** an op enqueued at edge T is selectable no earlier than cycle T+1; there is no same-cycle bypass.
- **Enqueue with dequeue:** simultaneous enqueue and dequeue are both applied; `count` changes by `popcount − 1`.
- **Redirect with enqueue:** enqueue is ignored and only the tail recomputation applies.
- **Redirect with select:** select is suppressed, so there is no dequeue in that cycle.
- **Full:** `enq_ready` is low while `count > DEPTH − ENQ_WIDTH`. It rises the cycle after a dequeue brings `count` back within bound.
- **Wrap-around:** pointer wrap toggles the wrap bit. Full is `count == DEPTH`, never an ambiguous `head == tail`.
- **Reset mid-operation:** reset dominates all events, drops S1/S2 contents, and loses no clock.

## Configuration

- **`ORDERED_IQ_PERF_EN` defined:** adds output `perf_stall_cnt` (32 bits, reset 0, saturating).
  - Increments each cycle the queue is non-empty, the head ROB index matches the commit ROB index, and `exu_ready` is low.
  - Also adds output `perf_full_cnt` (32 bits), which increments each cycle `enq_ready` is low and `|enq_valid` is high.
- **Undefined:** neither port exists and there is no counter logic.

## Test plan

1. Reset, then enqueue ROB idx 5 and 6 on lanes 0 and 1 with `commit_rob_idx=5` and `exu_ready=1`. Expect `rf_ren` in cycle 2 and `issue_valid` with ROB idx 5 in cycle 4. ROB idx 6 stays queued until `commit_rob_idx=6`.
2. With `enq_valid=2'b10` and ROB idx 9: the op lands at `head`, `count=1`, `enq_ready` stays 1.
3. `DEPTH=8`, `ENQ_WIDTH=2`: fill to `count=7`. Expect `enq_ready=0` and a held pair not accepted. After one issue, `count=6` and `enq_ready=1`.
4. Queue holds ROB idx 10, 11, 12, 13. Redirect with `redirect_rob_idx=11` gives next-cycle `count=2` and tail = head+2. A subsequent enqueue of ROB idx 12 reuses the freed slot.
5. Op selected at T and redirect at T+1 naming an older ROB idx: no `issue_valid` at T+2. If the redirect names an equal or younger ROB idx, issue proceeds.
6. Wrap: run 20 single enqueue/issue pairs through `DEPTH=8` with ROB indices crossing the flag flip (63→64 at `ROB_W=7`). Expect in-order issue with no loss. With `ORDERED_IQ_PERF_EN`, holding `exu_ready=0` for 3 matched cycles gives `perf_stall_cnt=3`.
